// File: rtl/keypad_id_entry.sv
// Keypad ID entry front end: synchronizes and debounces key presses and assembles BCD digits
// into a 32-bit ID. ENTER publishes the ID with a one-cycle valid strobe.
module keypad_id_entry #(
   parameter int DIGITS          = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_press,
   input  logic [3:0]  key_code,
   output logic [31:0] id,
   output logic        id_valid,
   output logic [3:0]  digit_count,
   output logic        entry_active,
   output logic        error
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ENTRY, COMMIT} state_t;

   state_t          state, state_next;
   logic            sync1, sync2;
   logic [DW-1:0]   deb_cnt;
   logic            new_evt;
   logic            key_evt;
   logic [3:0]      evt_code;
   logic [31:0]     buffer, buffer_next;
   logic [3:0]      count_next;
   logic            ovf, ovf_next;
   logic [TW-1:0]   tcnt, tcnt_next;
   logic [31:0]     id_next;
   logic            id_valid_next, error_next;
   logic            is_digit, is_clear, is_enter, timeout_hit;

   // The counter saturates one past the threshold, so each press yields exactly one event.
   assign new_evt = sync2 && (deb_cnt == DW'(DEBOUNCE_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         deb_cnt  <= '0;
         key_evt  <= 1'b0;
         evt_code <= 4'h0;
      end else begin
         sync1 <= key_press;
         sync2 <= sync1;
         if (!sync2)
            deb_cnt <= '0;
         else if (deb_cnt <= DW'(DEBOUNCE_CYCLES))
            deb_cnt <= deb_cnt + DW'(1);
         // An event landing during COMMIT is held over and consumed in IDLE.
         key_evt <= new_evt || (key_evt && (state == COMMIT));
         if (new_evt)
            evt_code <= key_code;
      end
   end

   assign is_digit    = (evt_code <= 4'd9);
   assign is_clear    = (evt_code == 4'hA);
   assign is_enter    = (evt_code == 4'hB);
   assign timeout_hit = (state == ENTRY) && !key_evt && (tcnt == TW'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:
            if (key_evt && is_digit)
               state_next = ENTRY;
         ENTRY:
            if (key_evt) begin
               if (is_clear)
                  state_next = IDLE;
               else if (is_enter)
                  state_next = ovf ? IDLE : COMMIT;
            end else if (timeout_hit) begin
               state_next = IDLE;
            end
         COMMIT:
            state_next = IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   always_comb begin
      buffer_next   = buffer;
      count_next    = digit_count;
      ovf_next      = ovf;
      tcnt_next     = '0;
      id_next       = id;
      id_valid_next = 1'b0;
      error_next    = 1'b0;
      case (state)
         IDLE:
            if (key_evt && is_digit) begin
               buffer_next = {28'b0, evt_code};
               count_next  = 4'd1;
               ovf_next    = 1'b0;
            end
         ENTRY: begin
            tcnt_next = tcnt + TW'(1);
            if (key_evt) begin
               tcnt_next = '0;
               if (is_digit) begin
                  if (digit_count < 4'(DIGITS)) begin
                     buffer_next = {buffer[27:0], evt_code};
                     count_next  = digit_count + 4'd1;
                  end else begin
                     ovf_next = 1'b1;
                  end
               end else if (is_clear || (is_enter && ovf)) begin
                  buffer_next = '0;
                  count_next  = 4'd0;
                  ovf_next    = 1'b0;
                  error_next  = is_enter;
               end
            end else if (timeout_hit) begin
               buffer_next = '0;
               count_next  = 4'd0;
               ovf_next    = 1'b0;
               tcnt_next   = '0;
               error_next  = 1'b1;
            end
         end
         COMMIT: begin
            id_next       = buffer;
            id_valid_next = 1'b1;
            buffer_next   = '0;
            count_next    = 4'd0;
            ovf_next      = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buffer      <= '0;
         digit_count <= 4'd0;
         ovf         <= 1'b0;
         tcnt        <= '0;
         id          <= '0;
         id_valid    <= 1'b0;
         error       <= 1'b0;
      end else begin
         buffer      <= buffer_next;
         digit_count <= count_next;
         ovf         <= ovf_next;
         tcnt        <= tcnt_next;
         id          <= id_next;
         id_valid    <= id_valid_next;
         error       <= error_next;
      end
   end

   assign entry_active = (state == ENTRY);

endmodule

// File: tb/tb_keypad_id_entry.sv
// Directed bench for keypad_id_entry with small debounce/timeout values and hand-computed IDs.
module tb_keypad_id_entry;

   localparam int T_CYC = 100;

   logic        clk;
   logic        rst;
   logic        key_press;
   logic [3:0]  key_code;
   logic [31:0] id;
   logic        id_valid;
   logic [3:0]  digit_count;
   logic        entry_active;
   logic        error;

   int checks_done;
   int checks_failed;
   int valid_pulses;
   int error_pulses;
   int v0, e0;
   bit seen;

   keypad_id_entry #(
      .DIGITS(8),
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES(T_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_press(key_press),
      .key_code(key_code),
      .id(id),
      .id_valid(id_valid),
      .digit_count(digit_count),
      .entry_active(entry_active),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters let each scenario check exactly how many strobes it caused.
   always @(negedge clk) begin
      if (id_valid) valid_pulses++;
      if (error) error_pulses++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_done++;
      if (got !== exp) begin
         checks_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] code);
      @(negedge clk);
      key_code  = code;
      key_press = 1'b1;
      repeat (8) @(negedge clk);
      key_press = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      checks_done   = 0;
      checks_failed = 0;
      valid_pulses  = 0;
      error_pulses  = 0;
      rst       = 1'b1;
      key_press = 1'b0;
      key_code  = 4'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset_id", id, 32'h0);
      checkOutput("reset_id_valid", {31'b0, id_valid}, 32'h0);
      checkOutput("reset_digit_count", {28'b0, digit_count}, 32'h0);
      checkOutput("reset_entry_active", {31'b0, entry_active}, 32'h0);
      checkOutput("reset_error", {31'b0, error}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] basic commit");
      v0 = valid_pulses; e0 = error_pulses;
      applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3); applyStimulus(4'h4);
      checkOutput("basic_count4", {28'b0, digit_count}, 32'd4);
      checkOutput("basic_active", {31'b0, entry_active}, 32'd1);
      applyStimulus(4'hB);
      checkOutput("basic_pulses", valid_pulses - v0, 32'd1);
      checkOutput("basic_id", id, 32'h0000_1234);
      checkOutput("basic_count0", {28'b0, digit_count}, 32'd0);
      checkOutput("basic_idle", {31'b0, entry_active}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("basic_id_hold", id, 32'h0000_1234);
      checkOutput("basic_no_error", error_pulses - e0, 32'd0);

      $display("[TB] bounce rejection");
      @(negedge clk);
      key_code = 4'h5; key_press = 1'b1;
      repeat (3) @(negedge clk);
      key_press = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("glitch_ignored", {28'b0, digit_count}, 32'd0);
      key_press = 1'b1;
      repeat (6) @(negedge clk);
      key_press = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("bounce_count1", {28'b0, digit_count}, 32'd1);
      applyStimulus(4'hA);
      checkOutput("bounce_clear", {28'b0, digit_count}, 32'd0);

      $display("[TB] overflow");
      v0 = valid_pulses; e0 = error_pulses;
      for (int d = 1; d <= 9; d++) applyStimulus(4'(d));
      checkOutput("ovf_count_sat", {28'b0, digit_count}, 32'd8);
      applyStimulus(4'hB);
      checkOutput("ovf_error", error_pulses - e0, 32'd1);
      checkOutput("ovf_no_valid", valid_pulses - v0, 32'd0);
      checkOutput("ovf_id_kept", id, 32'h0000_1234);
      checkOutput("ovf_idle", {31'b0, entry_active}, 32'd0);
      for (int d = 8; d >= 1; d--) applyStimulus(4'(d));
      applyStimulus(4'hB);
      checkOutput("full_valid", valid_pulses - v0, 32'd1);
      checkOutput("full_id", id, 32'h8765_4321);

      $display("[TB] clear and ignored codes");
      v0 = valid_pulses; e0 = error_pulses;
      applyStimulus(4'h7);
      checkOutput("clr_active", {31'b0, entry_active}, 32'd1);
      applyStimulus(4'hA);
      checkOutput("clr_inactive", {31'b0, entry_active}, 32'd0);
      applyStimulus(4'hE);
      checkOutput("ign_idle", {31'b0, entry_active}, 32'd0);
      checkOutput("ign_count", {28'b0, digit_count}, 32'd0);
      applyStimulus(4'h4);
      applyStimulus(4'hB);
      checkOutput("clr_id", id, 32'h0000_0004);
      checkOutput("clr_valid", valid_pulses - v0, 32'd1);
      checkOutput("clr_no_error", error_pulses - e0, 32'd0);

      $display("[TB] timeout");
      v0 = valid_pulses;
      @(negedge clk);
      key_code = 4'h3; key_press = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (entry_active) seen = 1'b1;
      end
      key_press = 1'b0;
      checkOutput("to_enter_entry", {31'b0, seen}, 32'd1);
      repeat (T_CYC - 2) @(negedge clk);
      checkOutput("to_not_yet", {31'b0, error}, 32'd0);
      checkOutput("to_still_active", {31'b0, entry_active}, 32'd1);
      @(negedge clk);
      checkOutput("to_error", {31'b0, error}, 32'd1);
      checkOutput("to_inactive", {31'b0, entry_active}, 32'd0);
      @(negedge clk);
      checkOutput("to_error_1cyc", {31'b0, error}, 32'd0);
      applyStimulus(4'hB);
      checkOutput("to_enter_alone", valid_pulses - v0, 32'd0);
      checkOutput("to_id_kept", id, 32'h0000_0004);

      $display("[TB] async reset mid-entry");
      applyStimulus(4'h6); applyStimulus(4'h6);
      checkOutput("rst_pre_count", {28'b0, digit_count}, 32'd2);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_id", id, 32'h0);
      checkOutput("rst_count", {28'b0, digit_count}, 32'd0);
      checkOutput("rst_active", {31'b0, entry_active}, 32'd0);
      checkOutput("rst_valid", {31'b0, id_valid}, 32'd0);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      v0 = valid_pulses;
      applyStimulus(4'h2);
      applyStimulus(4'hB);
      checkOutput("post_rst_id", id, 32'h0000_0002);
      checkOutput("post_rst_valid", valid_pulses - v0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks_done, checks_failed);
      $finish;
   end

endmodule
